// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
//
// Contents:
//   state_t        - controller states (IDLE, BUSY, DONE)
//   CNT_W          - iteration counter width for the default 16-bit dividend
//   cnt_width()    - counter width for any dividend width
//   DIV_ALL_ONES   - wide all-ones constant; sliced to DIVIDEND_W for the
//                    divide-by-zero quotient
package div_pkg;

  localparam int DIVIDEND_W_DEF = 16;
  localparam int DIVISOR_W_DEF  = 8;

  localparam int CNT_W = $clog2(DIVIDEND_W_DEF);

  // Wide enough for any practical dividend width; users slice it.
  localparam int          ALL_ONES_MAX_W = 64;
  localparam logic [63:0] DIV_ALL_ONES   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter has to hold DIVIDEND_W-1; keep at least one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
//
// Ports:
//   pr       in  DIVISOR_W+1  current partial remainder
//   sr_msb   in  1            next dividend bit shifted into the remainder
//   divisor  in  DIVISOR_W    denominator
//   pr_next  out DIVISOR_W+1  partial remainder after this iteration
//   q_bit    out 1            quotient bit resolved by this iteration
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W:0]   pr,
  input  logic                 sr_msb,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_next,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] t;
  logic [DIVISOR_W:0] diff;
  // After a restoring step the remainder is always < divisor, so the top
  // bit of pr is zero on entry and only the low DIVISOR_W bits carry data.
  logic               pr_msb_unused;

  assign pr_msb_unused = pr[DIVISOR_W];
  assign t             = {pr[DIVISOR_W-1:0], sr_msb};
  assign diff          = t - {1'b0, divisor};
  assign q_bit         = (t >= {1'b0, divisor});
  assign pr_next       = q_bit ? diff : t;

endmodule

// File: rtl/seq_div_16by8.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both input and output.
//
// Optional build macro: DIV_EARLY_EXIT_EN
//   When defined, operands with dividend < divisor (divisor != 0) finish in
//   a single cycle with quotient=0, remainder=dividend.
//
// Ports:
//   clk          in  1           rising-edge clock
//   rst_n        in  1           asynchronous active-low reset
//   in_valid     in  1           operands valid
//   in_ready     out 1           divider idle and able to accept operands
//   dividend     in  DIVIDEND_W  numerator
//   divisor      in  DIVISOR_W   denominator
//   out_valid    out 1           result valid (held until out_ready)
//   out_ready    in  1           consumer accepts result
//   quotient     out DIVIDEND_W  floor(dividend/divisor), all ones on /0
//   remainder    out DIVISOR_W   dividend mod divisor, dividend LSBs on /0
//   div_by_zero  out 1           result came from a zero divisor
module seq_div_16by8
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CW = (DIVIDEND_W == DIVIDEND_W_DEF) ? CNT_W : cnt_width(DIVIDEND_W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIVIDEND_W - 1);

  state_t                state_reg, state_next;
  logic [DIVISOR_W:0]    pr_reg, pr_next;
  logic [DIVIDEND_W-1:0] sr_reg, sr_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [DIVISOR_W-1:0]  divisor_reg, divisor_next;
  logic [DIVIDEND_W-1:0] quotient_reg, quotient_next;
  logic [DIVISOR_W-1:0]  remainder_reg, remainder_next;
  logic                  dbz_reg, dbz_next;

  logic [DIVISOR_W:0]    step_pr;
  logic                  step_q;

  // Single shared iteration; sr MSB is the next dividend bit to bring down.
  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .pr      (pr_reg),
    .sr_msb  (sr_reg[DIVIDEND_W-1]),
    .divisor (divisor_reg),
    .pr_next (step_pr),
    .q_bit   (step_q)
  );

`ifdef DIV_EARLY_EXIT_EN
  logic early_exit;
  assign early_exit = (divisor != '0) && (dividend < DIVIDEND_W'(divisor));
`endif

  always_comb begin
    state_next     = state_reg;
    pr_next        = pr_reg;
    sr_next        = sr_reg;
    cnt_next       = cnt_reg;
    divisor_next   = divisor_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          divisor_next = divisor;
          if (divisor == '0) begin
            quotient_next  = DIV_ALL_ONES[DIVIDEND_W-1:0];
            remainder_next = dividend[DIVISOR_W-1:0];
            dbz_next       = 1'b1;
            state_next     = DONE;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (early_exit) begin
            quotient_next  = '0;
            remainder_next = dividend[DIVISOR_W-1:0];
            dbz_next       = 1'b0;
            state_next     = DONE;
          end
`endif
          else begin
            pr_next    = '0;
            sr_next    = dividend;
            cnt_next   = CNT_LOAD;
            dbz_next   = 1'b0;
            state_next = BUSY;
          end
        end
      end

      BUSY: begin
        // Dividend bits leave at the top of sr while quotient bits enter at
        // the bottom, so after the last step sr holds the whole quotient.
        pr_next = step_pr;
        sr_next = {sr_reg[DIVIDEND_W-2:0], step_q};
        if (cnt_reg == '0) begin
          quotient_next  = sr_next;
          remainder_next = step_pr[DIVISOR_W-1:0];
          state_next     = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pr_reg        <= '0;
      sr_reg        <= '0;
      cnt_reg       <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pr_reg        <= pr_next;
      sr_reg        <= sr_next;
      cnt_reg       <= cnt_next;
      divisor_reg   <= divisor_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_div_16by8.sv
// Self-checking bench for seq_div_16by8 (default 16/8 configuration).
// Expected results are pushed to a scoreboard queue at acceptance and
// popped when the divider presents its result.
module tb_seq_div_16by8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  seq_div_16by8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] dd, input logic [7:0] dv);
    exp_t e;
    e.dd = dd;
    e.dv = dv;
    if (dv == 8'd0) begin
      e.q   = 16'hFFFF;
      e.r   = dd[7:0];
      e.dbz = 1'b1;
    end else begin
      e.q   = 16'(int'(dd) / int'(dv));
      e.r   = 8'(int'(dd) % int'(dv));
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Presents one operand pair; returns #1 after the accepting edge with the
  // operand bus scrambled so late sampling would be visible.
  task automatic drive_op(input logic [15:0] dd, input logic [7:0] dv);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    sb.push_back(model(dd, dv));
  endtask

  // lat counts rising edges from the accepting edge (inclusive) to the edge
  // after which out_valid is seen; bounded at 100.
  task automatic wait_valid(output int lat, output bit rdy_seen);
    lat = 1;
    rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_values: rdy=%0b vld=%0b q=%0h r=%0h dbz=%0b want rdy=1 vld=0 q=0 r=0 dbz=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e; int lat; bit rs;
    out_ready = 1'b1;
    drive_op(16'd1000, 8'd7);
    wait_valid(lat, rs);
    e = sb.pop_front();
    n_cmp++;
    if (lat != 17) begin
      n_bad++; $display("FAIL basic_latency: got %0d want 17", lat);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz} || e.q != 16'd142 || e.r != 8'd6) begin
      n_bad++;
      $display("FAIL basic_result 1000/7: got q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=%0b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL basic_handshake: vld=%0b rdy=%0b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_extremes();
    exp_t e; int lat; bit rs;
    logic [15:0] dds [2] = '{16'd65535, 16'd0};
    logic [7:0]  dvs [2] = '{8'd1, 8'd200};
    for (int k = 0; k < 2; k++) begin
      drive_op(dds[k], dvs[k]);
      wait_valid(lat, rs);
      e = sb.pop_front();
      n_cmp++;
      if (rs !== 1'b0 || in_ready !== 1'b0) begin
        n_bad++; $display("FAIL extremes_in_ready op%0d: high during BUSY/DONE (seen=%0b now=%0b) want 0", k, rs, in_ready);
      end
      n_cmp++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        n_bad++;
        $display("FAIL extremes_result %0d/%0d: got q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=%0b",
                 e.dd, e.dv, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    exp_t e; int lat; bit rs;
    drive_op(16'h1234, 8'd0);
    wait_valid(lat, rs);
    e = sb.pop_front();
    n_cmp++;
    if (lat != 1) begin
      n_bad++; $display("FAIL divzero_latency: got %0d want 1", lat);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 8'h34, 1'b1} || {e.q, e.r, e.dbz} !== {quotient, remainder, div_by_zero}) begin
      n_bad++;
      $display("FAIL divzero_result: got q=%0h r=%0h dbz=%0b want q=%0h r=%0h dbz=%0b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    @(posedge clk); #1;
    drive_op(16'd10, 8'd3);
    wait_valid(lat, rs);
    e = sb.pop_front();
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_bad++;
      $display("FAIL after_divzero 10/3: got q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=%0b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    exp_t e; int lat; bit rs;
    out_ready = 1'b0;
    drive_op(16'd5000, 8'd13);
    wait_valid(lat, rs);
    e = sb.pop_front();
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        n_bad++;
        $display("FAIL backpressure_hold cyc%0d: vld=%0b q=%0d r=%0d want vld=1 q=%0d r=%0d",
                 c, out_valid, quotient, remainder, e.q, e.r);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL backpressure_before_release: vld=%0b want 1", out_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL backpressure_release: vld=%0b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; int lat; bit rs;
    drive_op(16'd40000, 8'd200);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_mid: vld=%0b rdy=%0b q=%0h want vld=0 rdy=1 q=0", out_valid, in_ready, quotient);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(16'd81, 8'd9);
    wait_valid(lat, rs);
    e = sb.pop_front();
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz} || lat != 17) begin
      n_bad++;
      $display("FAIL after_reset 81/9: got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=17",
               quotient, remainder, lat, e.q, e.r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_small_dividend();
    exp_t e; int lat; bit rs; int want_lat;
`ifdef DIV_EARLY_EXIT_EN
    want_lat = 1;
`else
    want_lat = 17;
`endif
    drive_op(16'd200, 8'd255);
    wait_valid(lat, rs);
    e = sb.pop_front();
    n_cmp++;
    if (lat != want_lat) begin
      n_bad++; $display("FAIL small_latency: got %0d want %0d", lat, want_lat);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'd0, 8'd200, 1'b0}) begin
      n_bad++;
      $display("FAIL small_result 200/255: got q=%0d r=%0d dbz=%0b want q=0 r=200 dbz=0",
               quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    exp_t e; int lat; bit rs;
    logic [15:0] dd; logic [7:0] dv;
    for (int k = 0; k < 2000; k++) begin
      dd = 16'($urandom);
      dv = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      drive_op(dd, dv);
      wait_valid(lat, rs);
      e = sb.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz} ||
          (dv != 0 && (int'(quotient) * int'(dv) + int'(remainder) != int'(dd) || remainder >= dv))) begin
        n_bad++;
        $display("FAIL random %0d/%0d: vld=%0b q=%0d r=%0d dbz=%0b want q=%0d r=%0d dbz=%0b",
                 dd, dv, out_valid, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_small_dividend();
    test_random();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
